reg_write_sequencer: RTL and testbench

// - Bus initiator for the signal generator register port (write_strobe/address/data).
// - Steps through a fixed table of register writes and issues one single-cycle write
//   per step, then waits a programmed number of tempo ticks before the next step.
// - Plays tunes and effects (period/volume/enable changes) with no host involvement.

---
 rtl/sg_pkg.sv | 49 ++++
 rtl/reg_write_sequencer_if.sv | 16 +
 rtl/seq_rom.sv | 54 +++++
 rtl/reg_write_sequencer.sv | 122 ++++++++++++
 tb/tb_reg_write_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sg_pkg.sv
// Shared definitions for the register-write sequencer and the signal generator.
//   - Sequencer FSM state encodings
//   - Register port widths and the END marker address
//   - Layout of a 16-bit sequence table word and a helper to build one
//   - Register address map of the signal generator
package sg_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 5;
    localparam int WORD_DLY_W = 8;
    localparam int WORD_W = ADDR_W + DATA_W + WORD_DLY_W;

    // Field offsets inside a table word {addr, data, delay}
    localparam int DLY_LSB  = 0;
    localparam int DATA_LSB = DLY_LSB + WORD_DLY_W;
    localparam int ADDR_LSB = DATA_LSB + DATA_W;

    // Address 7 is not decoded by the signal generator, so it marks end-of-table
    localparam logic [ADDR_W-1:0] END_ADDR = 3'b111;

    // Register address map
    localparam logic [ADDR_W-1:0] PERIOD_A = 3'd0;
    localparam logic [ADDR_W-1:0] PERIOD_B = 3'd1;
    localparam logic [ADDR_W-1:0] VOL_A    = 3'd2;
    localparam logic [ADDR_W-1:0] VOL_B    = 3'd3;
    localparam logic [ADDR_W-1:0] VOL_N    = 3'd4;
    localparam logic [ADDR_W-1:0] ENABLES  = 3'd5;

    // Sequencer FSM states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_WRAP   = 3'd5;

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W-1:0]     data;
        logic [WORD_DLY_W-1:0] delay;
    } seq_word_t;

    function automatic logic [WORD_W-1:0] mk_word(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] d,
                                                  input logic [WORD_DLY_W-1:0] dl);
        return {a, d, dl};
    endfunction

endpackage

// File: rtl/reg_write_sequencer_if.sv
// Register write port between the sequencer (master) and the signal generator
// (slave).
//   write_strobe : one-cycle write pulse
//   address      : register address, valid while write_strobe=1
//   data         : register data, valid while write_strobe=1
interface reg_write_sequencer_if;
    import sg_pkg::*;

    logic              write_strobe;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;

    modport master (output write_strobe, address, data);
    modport slave  (input  write_strobe, address, data);

endinterface

// File: rtl/seq_rom.sv
// Constant sequence table, combinational read.
//   idx  : table index (IDX_W bits)
//   word : {addr[2:0], data[4:0], delay[7:0]}
// TUNE selects one of several built-in tables; unlisted indices read as END.
module seq_rom
    import sg_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TUNE  = 0
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        word = mk_word(END_ADDR, '0, '0);
        case (TUNE)
            // Short two-step pattern: one delayed write, one immediate write
            1: begin
                case (int'(idx))
                    0:       word = mk_word(3'd2, 5'd8, 8'd2);
                    1:       word = mk_word(3'd3, 5'd5, 8'd0);
                    default: word = mk_word(END_ADDR, '0, '0);
                endcase
            end
            // Every entry used, no END marker, all delays zero
            2: word = mk_word(3'(int'(idx) % 6), 5'(int'(idx)), 8'd0);
            // Immediate write followed by a very long hold
            3: begin
                case (int'(idx))
                    0:       word = mk_word(3'd1, 5'd3, 8'd0);
                    1:       word = mk_word(3'd0, 5'd7, 8'd255);
                    default: word = mk_word(END_ADDR, '0, '0);
                endcase
            end
            // Empty table: END marker at step 0
            4: word = mk_word(END_ADDR, '0, '0);
            // Demo tune: enable channel A, fade through three periods, silence
            default: begin
                case (int'(idx))
                    0:       word = mk_word(ENABLES,  5'b00011, 8'd0);
                    1:       word = mk_word(VOL_A,    5'd20,    8'd0);
                    2:       word = mk_word(PERIOD_A, 5'd16,    8'd50);
                    3:       word = mk_word(PERIOD_A, 5'd12,    8'd50);
                    4:       word = mk_word(PERIOD_A, 5'd10,    8'd100);
                    5:       word = mk_word(VOL_A,    5'd0,     8'd0);
                    6:       word = mk_word(ENABLES,  5'd0,     8'd0);
                    default: word = mk_word(END_ADDR, '0, '0);
                endcase
            end
        endcase
    end

endmodule

// File: rtl/reg_write_sequencer.sv
// Autonomous bus initiator: walks the seq_rom table, issues one single-cycle
// register write per entry, then waits delay*TICK_DIV cycles before the next.
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : begin playback from step 0 when idle (level sampled)
//   stop        : abort playback (level sampled, wins over start)
//   loop_en     : restart from step 0 at end of table / END marker
//   bus         : register write port (write_strobe/address/data)
//   busy        : high whenever the FSM is not idle
//   step        : current or most recent table index
// Table words are 16 bits, so DLY_W must stay at 8.
module reg_write_sequencer
    import sg_pkg::*;
#(
    parameter int STEPS    = 16,
    parameter int IDX_W    = 4,
    parameter int TICK_DIV = 1000,
    parameter int DLY_W    = 8,
    parameter int TUNE     = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    reg_write_sequencer_if.master  bus,
    output logic                   busy,
    output logic [IDX_W-1:0]       step
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [2:0]        state_reg, state_next;
    logic [IDX_W-1:0]  step_reg;
    logic [ADDR_W-1:0] addr_reg;      // address of the latched word, incl. END
    logic [DLY_W-1:0]  dly_reg;       // delay of the latched word
    logic [ADDR_W-1:0] address_reg;
    logic [DATA_W-1:0] data_reg;
    logic              strobe_reg;
    logic              busy_reg;
    logic [PRE_W-1:0]  pre_reg;
    logic [DLY_W-1:0]  cnt_reg;

    seq_word_t rom_word;
    logic      tick_wrap;
    logic      end_at_zero;

    seq_rom #(.IDX_W(IDX_W), .TUNE(TUNE)) u_rom (
        .idx  (step_reg),
        .word (rom_word)
    );

    assign tick_wrap   = (pre_reg == PRE_W'(TICK_DIV - 1));
    // An END marker at step 0 would otherwise loop forever without writing
    assign end_at_zero = (step_reg == '0) && (addr_reg == END_ADDR);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start && !stop) state_next = S_LOAD;
            S_LOAD:   state_next = (rom_word.addr == END_ADDR) ? S_WRAP : S_STROBE;
            S_STROBE: state_next = (dly_reg == '0) ? S_NEXT : S_HOLD;
            S_HOLD:   if (tick_wrap && cnt_reg == DLY_W'(1)) state_next = S_NEXT;
            S_NEXT:   state_next = (step_reg == IDX_W'(STEPS - 1)) ? S_WRAP : S_LOAD;
            S_WRAP:   state_next = (loop_en && !end_at_zero) ? S_LOAD : S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (stop && state_reg != S_IDLE) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            step_reg    <= '0;
            addr_reg    <= '0;
            dly_reg     <= '0;
            address_reg <= '0;
            data_reg    <= '0;
            strobe_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            pre_reg     <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            // Outputs are registered from the next state so they line up with it
            busy_reg   <= (state_next != S_IDLE);
            strobe_reg <= (state_next == S_STROBE);
            case (state_reg)
                S_IDLE: if (state_next == S_LOAD) step_reg <= '0;
                S_LOAD: begin
                    addr_reg <= rom_word.addr;
                    dly_reg  <= rom_word.delay;
                    if (state_next == S_STROBE) begin
                        address_reg <= rom_word.addr;
                        data_reg    <= rom_word.data;
                    end
                end
                S_STROBE: begin
                    pre_reg <= '0;
                    cnt_reg <= dly_reg;
                end
                S_HOLD: begin
                    if (tick_wrap) begin
                        pre_reg <= '0;
                        cnt_reg <= cnt_reg - DLY_W'(1);
                    end else begin
                        pre_reg <= pre_reg + PRE_W'(1);
                    end
                end
                S_NEXT: if (state_next == S_LOAD) step_reg <= step_reg + IDX_W'(1);
                S_WRAP: if (state_next == S_LOAD) step_reg <= '0;
                default: ;
            endcase
        end
    end

    assign bus.write_strobe = strobe_reg;
    assign bus.address      = address_reg;
    assign bus.data         = data_reg;
    assign busy             = busy_reg;
    assign step             = step_reg;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed bench for reg_write_sequencer. Four instances with TICK_DIV=4 and
// different built-in tables (TUNE 1..4) share clock, reset, stop and loop_en;
// each has its own start. Strobes of the instance under test are logged with
// their cycle number counted from the start-sampling edge E0.
module tb_reg_write_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stop;
    logic       loop_en;
    logic       start [4];
    logic       busy  [4];
    logic [3:0] step  [4];
    logic       ws    [4];
    logic [2:0] ad    [4];
    logic [4:0] dt    [4];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        reg_write_sequencer_if bus ();
        reg_write_sequencer #(
            .STEPS(16), .IDX_W(4), .TICK_DIV(4), .DLY_W(8), .TUNE(gi + 1)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start[gi]),
            .stop    (stop),
            .loop_en (loop_en),
            .bus     (bus),
            .busy    (busy[gi]),
            .step    (step[gi])
        );
        assign ws[gi] = bus.write_strobe;
        assign ad[gi] = bus.address;
        assign dt[gi] = bus.data;
    end

    int         checks = 0;
    int         failures = 0;
    int         kc = 0;
    int         cur = 0;
    int         sk [$];
    logic [2:0] sa [$];
    logic [4:0] sd [$];
    logic       bh [0:255];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int qk(input int i);
        return (i < sk.size()) ? sk[i] : -1;
    endfunction
    function automatic int qa(input int i);
        return (i < sa.size()) ? int'(sa[i]) : -1;
    endfunction
    function automatic int qd(input int i);
        return (i < sd.size()) ? int'(sd[i]) : -1;
    endfunction

    task automatic clear_log(input int d);
        cur = d;
        kc  = 0;
        sk.delete();
        sa.delete();
        sd.delete();
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge
    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            kc++;
            if (kc < 256) bh[kc] = busy[cur];
            if (ws[cur] === 1'b1) begin
                sk.push_back(kc);
                sa.push_back(ad[cur]);
                sd.push_back(dt[cur]);
                $display("dut=%0d k=%0d write addr=%0d data=%0d step=%0d",
                         cur, kc, ad[cur], dt[cur], step[cur]);
            end
        end
    endtask

    // Drive start for exactly one edge (E0); kc=0 right after E0
    task automatic begin_run(input int d);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        clear_log(d);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step_cycles(1);
        stop = 1'b0;
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        for (int d = 0; d < 4; d++) start[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_strobe%0d", d), 32'(ws[d]), 0);
            chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 0);
            chk($sformatf("rst_step%0d", d), 32'(step[d]), 0);
            chk($sformatf("rst_addr%0d", d), 32'(ad[d]), 0);
            chk($sformatf("rst_data%0d", d), 32'(dt[d]), 0);
        end
        rst_n = 1'b1;
        step_cycles(2);

        // Single pass: (2,8,d=2), (3,5,d=0), END
        loop_en = 1'b0;
        begin_run(0);
        step_cycles(30);
        chk("single_n", 32'(sk.size()), 2);
        chk("single_k0", 32'(qk(0)), 1);
        chk("single_a0", 32'(qa(0)), 2);
        chk("single_d0", 32'(qd(0)), 8);
        chk("single_k1", 32'(qk(1)), 12);
        chk("single_a1", 32'(qa(1)), 3);
        chk("single_d1", 32'(qd(1)), 5);
        chk("single_busy", 32'(busy[0]), 0);
        chk("single_step", 32'(step[0]), 2);

        // Loop, with a start pulse while busy that must not disturb timing
        loop_en = 1'b1;
        begin_run(0);
        step_cycles(4);
        start[0] = 1'b1;
        step_cycles(1);
        start[0] = 1'b0;
        step_cycles(15);
        chk("loop_n", 32'(sk.size()), 3);
        chk("loop_k1", 32'(qk(1)), 12);
        chk("loop_k2", 32'(qk(2)), 17);
        chk("loop_a2", 32'(qa(2)), 2);
        chk("loop_d2", 32'(qd(2)), 8);
        pulse_stop();
        chk("loop_stop_busy", 32'(busy[0]), 0);
        chk("loop_stop_step", 32'(step[0]), 0);
        step_cycles(10);
        chk("loop_stop_n", 32'(sk.size()), 3);

        // Reset asserted for 3 cycles during HOLD
        loop_en = 1'b0;
        begin_run(0);
        step_cycles(4);
        rst_n = 1'b0;
        step_cycles(1);
        chk("rst_mid_strobe", 32'(ws[0]), 0);
        chk("rst_mid_busy", 32'(busy[0]), 0);
        chk("rst_mid_step", 32'(step[0]), 0);
        chk("rst_mid_addr", 32'(ad[0]), 0);
        step_cycles(2);
        rst_n = 1'b1;
        step_cycles(20);
        chk("rst_mid_n", 32'(sk.size()), 1);
        chk("rst_mid_busy_after", 32'(busy[0]), 0);

        // Full table, no END, all delays zero
        loop_en = 1'b0;
        begin_run(1);
        step_cycles(60);
        chk("full_n", 32'(sk.size()), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full_k%0d", i), 32'(qk(i)), 32'(1 + 3 * i));
            chk($sformatf("full_a%0d", i), 32'(qa(i)), 32'(i % 6));
            chk($sformatf("full_d%0d", i), 32'(qd(i)), 32'(i));
        end
        chk("full_busy47", 32'(bh[47]), 1);
        chk("full_busy48", 32'(bh[48]), 1);
        chk("full_busy49", 32'(bh[49]), 0);
        chk("full_step", 32'(step[1]), 15);

        // Stop during a 255-tick hold at step 1, then restart
        loop_en = 1'b0;
        begin_run(2);
        step_cycles(10);
        chk("hold_n", 32'(sk.size()), 2);
        chk("hold_k1", 32'(qk(1)), 4);
        chk("hold_a1", 32'(qa(1)), 0);
        chk("hold_d1", 32'(qd(1)), 7);
        pulse_stop();
        chk("hold_stop_busy", 32'(busy[2]), 0);
        chk("hold_stop_step", 32'(step[2]), 1);
        step_cycles(1);
        n = sk.size();
        chk("hold_stop_quiet", 32'(n), 2);
        begin_run(2);
        step_cycles(3);
        chk("restart_n", 32'(sk.size()), 1);
        chk("restart_k0", 32'(qk(0)), 1);
        chk("restart_a0", 32'(qa(0)), 1);
        chk("restart_d0", 32'(qd(0)), 3);
        chk("restart_step", 32'(step[2]), 1);
        pulse_stop();
        chk("restart_stop_busy", 32'(busy[2]), 0);

        // start and stop together in IDLE
        clear_log(3);
        start[3] = 1'b1;
        stop     = 1'b1;
        step_cycles(1);
        start[3] = 1'b0;
        stop     = 1'b0;
        chk("startstop_busy", 32'(busy[3]), 0);
        step_cycles(3);
        chk("startstop_busy_later", 32'(busy[3]), 0);
        chk("startstop_n", 32'(sk.size()), 0);

        // END at step 0 with looping enabled
        loop_en = 1'b1;
        begin_run(3);
        step_cycles(3);
        chk("end0_busy1", 32'(bh[1]), 1);
        chk("end0_busy2", 32'(bh[2]), 0);
        step_cycles(10);
        chk("end0_n", 32'(sk.size()), 0);
        chk("end0_busy_final", 32'(busy[3]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
